// File: rtl/da_pkg.sv
// Shared types and constants for the distributed-arithmetic address generator.
package da_pkg;
  typedef enum logic {IDLE, SHIFT} gen_state_t;
  localparam int T_W = 8;
  // 1: an address bit of 1 means "same bit value as the reference element"
  localparam logic OBC_XNOR = 1'b1;
endpackage

// File: rtl/obc_slice.sv
// Combinational OBC encode of one bit slice: reference bit plus per-element
// agreement against it.
module obc_slice
  import da_pkg::*;
#(
  parameter int K = 9
) (
  input  logic [K-1:0] bits,
  output logic         a0,
  output logic [K-2:0] addr
);
  always_comb begin
    a0 = bits[0];
    for (int j = 0; j < K - 1; j++) begin
      addr[j] = bits[j+1] ^ bits[0] ^ OBC_XNOR;
    end
  end
endmodule

// File: rtl/da_addr_gen.sv
// Bit-serial OBC slice generator, LSB first; slice 0 appears the cycle after accept.
// One vector is double-buffered in a shadow register; in_ready drops only while it is full.
module da_addr_gen
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 16,
  parameter int K = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH_A-1:0] A_in [K],
  output logic                           A0,
  output logic [K-2:0]                   addr_array,
  output logic [T_W-1:0]                 t,
  output logic                           gen_done,
  output logic                           slice_last
);
  localparam int IDX_W = $clog2(DATA_WIDTH_A);
  localparam logic [T_W-1:0] T_LAST = T_W'(DATA_WIDTH_A - 1);

  gen_state_t state, state_nxt;
  logic [DATA_WIDTH_A-1:0] act [K];
  logic [DATA_WIDTH_A-1:0] shd [K];
  logic shd_full, shd_full_nxt;
  logic accept, load_act_in, load_act_shd, load_shd, gen_nxt;
  logic [T_W-1:0] t_nxt;
  logic [IDX_W-1:0] bit_idx;
  logic [K-1:0] slice_bits;
  logic a0_nxt;
  logic [K-2:0] addr_nxt;

  assign in_ready = !shd_full;
  assign accept   = in_valid && !shd_full;

  always_comb begin
    state_nxt    = state;
    shd_full_nxt = shd_full;
    load_act_in  = 1'b0;
    load_act_shd = 1'b0;
    load_shd     = 1'b0;
    gen_nxt      = 1'b0;
    t_nxt        = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_act_in = 1'b1;
          gen_nxt     = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (t != T_LAST) begin
          t_nxt   = t + 1'b1;
          gen_nxt = 1'b1;
          if (accept) begin
            load_shd     = 1'b1;
            shd_full_nxt = 1'b1;
          end
        end else if (shd_full) begin
          load_act_shd = 1'b1;
          shd_full_nxt = 1'b0;
          gen_nxt      = 1'b1;
        end else if (accept) begin
          // Incoming vector bypasses the shadow so the stream has no bubble
          load_act_in = 1'b1;
          gen_nxt     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bit_idx = t_nxt[IDX_W-1:0];

  always_comb begin
    for (int k = 0; k < K; k++) begin
      if (load_act_in)       slice_bits[k] = A_in[k][0];
      else if (load_act_shd) slice_bits[k] = shd[k][0];
      else                   slice_bits[k] = act[k][bit_idx];
    end
  end

  obc_slice #(.K(K)) u_obc (
    .bits (slice_bits),
    .a0   (a0_nxt),
    .addr (addr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shd_full   <= 1'b0;
      t          <= '0;
      gen_done   <= 1'b0;
      slice_last <= 1'b0;
      A0         <= 1'b0;
      addr_array <= '0;
      for (int k = 0; k < K; k++) begin
        act[k] <= '0;
        shd[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      shd_full   <= shd_full_nxt;
      t          <= t_nxt;
      gen_done   <= gen_nxt;
      slice_last <= gen_nxt && (t_nxt == T_LAST);
      A0         <= gen_nxt && a0_nxt;
      addr_array <= gen_nxt ? addr_nxt : '0;
      for (int k = 0; k < K; k++) begin
        if (load_act_in)       act[k] <= A_in[k];
        else if (load_act_shd) act[k] <= shd[k];
        if (load_shd)          shd[k] <= A_in[k];
      end
    end
  end
endmodule

// File: tb/tb_da_addr_gen.sv
// Directed bench for da_addr_gen: single, equal, back-to-back, last-slice accept, async reset.
module tb_da_addr_gen;
  localparam int W = 16;
  localparam int K = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] a_in [K];
  logic a0;
  logic [K-2:0] addr;
  logic [7:0] t;
  logic gen_done, slice_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] vecs [5][K];
  logic [W-1:0] rec [K];

  always #5 clk = ~clk;

  da_addr_gen #(.DATA_WIDTH_A(W), .K(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A_in       (a_in),
    .A0         (a0),
    .addr_array (addr),
    .t          (t),
    .gen_done   (gen_done),
    .slice_last (slice_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int n);
    for (int k = 0; k < K; k++) a_in[k] = vecs[n][k];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gen_done"}, gen_done, 0);
    chk({tag, ".slice_last"}, slice_last, 0);
    chk({tag, ".a0"}, a0, 0);
    chk({tag, ".addr"}, addr, 0);
    chk({tag, ".t"}, t, 0);
  endtask

  task automatic chk_slice(input string tag, input int i, input logic ea0,
                           input logic [K-2:0] eaddr, input logic erdy);
    chk($sformatf("%s.a0[%0d]", tag, i), a0, ea0);
    chk($sformatf("%s.addr[%0d]", tag, i), addr, eaddr);
    chk($sformatf("%s.t[%0d]", tag, i), t, i);
    chk($sformatf("%s.gen_done[%0d]", tag, i), gen_done, 1);
    chk($sformatf("%s.slice_last[%0d]", tag, i), slice_last, (i == W - 1));
    chk($sformatf("%s.in_ready[%0d]", tag, i), in_ready, erdy);
  endtask

  function automatic logic [K-2:0] exp_addr(input int n, input int b);
    logic [K-2:0] r;
    for (int j = 0; j < K - 1; j++) r[j] = (vecs[n][j+1][b] == vecs[n][0][b]);
    return r;
  endfunction

  // Checks one slice against the encoding model and rebuilds the vector from the stream.
  task automatic chk_vec_slice(input string tag, input int n, input int i, input logic erdy);
    chk_slice(tag, i, vecs[n][0][i], exp_addr(n, i), erdy);
    rec[0][i] = a0;
    for (int j = 0; j < K - 1; j++) rec[j+1][i] = addr[j] ? a0 : ~a0;
  endtask

  task automatic chk_rec(input string tag, input int n);
    for (int k = 0; k < K; k++) chk($sformatf("%s.rec[%0d]", tag, k), rec[k], vecs[n][k]);
  endtask

  initial begin
    vecs[0] = '{16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
                16'h8001, 16'h8001, 16'h8001, 16'h8001};
    vecs[2] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h00FF, 16'h7FFF,
                16'hA5A5, 16'h0001, 16'hFFFE, 16'h5A5A};
    vecs[3] = '{16'hF00D, 16'h0BAD, 16'hCAFE, 16'h1357, 16'h2468,
                16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0};
    vecs[4] = '{16'h00AA, 16'h0055, 16'hFF00, 16'h1111, 16'h2222,
                16'h3333, 16'h4444, 16'h5555, 16'h6666};
    for (int k = 0; k < K; k++) a_in[k] = '0;

    // Reset state
    repeat (2) step();
    chk_idle("reset");
    chk("reset.in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Single vector: reference 5, others 0
    load_vec(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) step();
      chk_slice("single", i, (i == 0 || i == 2), (i == 0 || i == 2) ? 8'h00 : 8'hFF, 1'b1);
    end
    step();
    chk_idle("single_after");

    // All elements 16'h8001
    load_vec(1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) step();
      chk_slice("equal", i, (i == 0 || i == W - 1), 8'hFF, 1'b1);
    end
    step();
    chk_idle("equal_after");

    // Back-to-back: second vector offered at t=3 of the first
    load_vec(2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) step();
      if (i == 4) in_valid = 1'b0;
      chk_vec_slice("b2b_first", 2, i, (i <= 3));
      if (i == 3) begin
        load_vec(3);
        in_valid = 1'b1;
      end
    end
    chk_rec("b2b_first", 2);
    for (int i = 0; i < W; i++) begin
      step();
      chk_vec_slice("b2b_second", 3, i, 1'b1);
      if (i == W - 1) begin
        load_vec(4);
        in_valid = 1'b1;
      end
    end
    chk_rec("b2b_second", 3);

    // Accept on the last slice with an empty shadow, then async reset at t=7
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) in_valid = 1'b0;
      chk_vec_slice("lastacc", 4, i, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst.in_ready", in_ready, 1);
    step();
    chk_idle("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("post_rst%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
